instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch stage of the multi-cycle MIPS core. Owns the program counter and the instruction register.
- Fetches words from instruction memory over a req/ack handshake and presents the opcode to the control unit.
- At the end of each instruction it consumes the control unit's PC_in_mux and branch outputs, plus the ALU zero flag, to select the next PC.
- PC is word-addressed: sequential step is +1.

Parameters:
PC_WIDTH, 32, width of PC and instruction memory address (must be >= 27)
INSTR_WIDTH, 32, instruction word width (fixed 32 in this core)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  instruction memory read request
imem_addr  out  PC_WIDTH  instruction memory word address (= pc)
imem_rdata  in  INSTR_WIDTH  instruction word, valid when imem_ack=1
imem_ack  in  1  read complete; sampled only while imem_req=1
PC_in_mux  in  2  next-PC select from control unit
branch  in  1  conditional branch (BNE) from control unit
alu_zero  in  1  ALU result == 0
reg_target  in  PC_WIDTH  register bank read data 1 (JR/JM target)
stall  in  1  hold current instruction (data memory busy)
instr  out  INSTR_WIDTH  instruction register
opcode  out  6  instr[31:26], to control unit
instr_valid  out  1  instr is current and being executed
pc  out  PC_WIDTH  address of current instruction
pc_plus_one  out  PC_WIDTH  pc+1, link value for JAL
retire_count  out  32  retired instruction count (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, instr=0.
  - imem_req=0, instr_valid=0, retire_count=0.
  - Outputs take these values immediately, independent of clk, including an abort mid-fetch or mid-EXEC; no memory-side cleanup.
- States: IDLE, FETCH, EXEC.
- IDLE: imem_req=0. Next cycle -> FETCH unconditionally.
- FETCH:
  - imem_req=1, imem_addr=pc held stable until ack.
  - imem_ack=1 in the same cycle req is high (zero-wait memory) is legal.
  - On ack: instr<=imem_rdata, -> EXEC. No ack: stay in FETCH.
- EXEC: instr_valid=1; opcode/instr are stable for the whole state.
  - stall=1: stay in EXEC, pc and instr unchanged.
  - stall=0: pc<=next_pc, retire event, -> FETCH.
- Minimum latency: 2 cycles per instruction (FETCH with immediate ack, then EXEC).
- next_pc, all arithmetic modulo 2^PC_WIDTH (0xFFFFFFFF+1 wraps to 0):
  - PC_in_mux=0, branch=1, alu_zero=0: pc_plus_one + sign_extend(instr[15:0]).
  - PC_in_mux=0 otherwise: pc_plus_one.
  - PC_in_mux=1: {pc_plus_one[PC_WIDTH-1:26], instr[25:0]}.
  - PC_in_mux=2: reg_target.
  - PC_in_mux=3 (reserved): pc_plus_one.
- branch and alu_zero are ignored unless PC_in_mux=0. X on branch with PC_in_mux!=0 must not propagate into pc.
- imem_ack while imem_req=0 is ignored. imem_rdata is don't-care without ack.
- pc_plus_one is combinational from pc.

Optional Feature:
- Macro RETIRE_COUNT_EN.
- Defined: retire_count is a 32-bit register that increments by 1 on each EXEC->FETCH transition, wraps 0xFFFFFFFF->0, and does not count stalled cycles.
- Undefined: retire_count tied to 0 and no counter register is synthesized. The port remains, so the interface is unchanged.

Test Plan:
- Reset, then release with RESET_PC=0 and zero-wait ack, instr=0x04000000 (opcode 1), PC_in_mux=0 -> IDLE 1 cycle; req with addr 0; EXEC with opcode=1; next fetch addr 1.
- BNE at pc=0x10, instr[15:0]=0xFFFC, branch=1, alu_zero=0 -> next addr 0x0D. Same with alu_zero=1 -> 0x11.
- J at pc=0x10, instr=0x1C000040, PC_in_mux=1 -> next addr 0x40. JR with PC_in_mux=2, reg_target=0x1234 -> next addr 0x1234. PC_in_mux=1 with branch=X -> pc not X.
- Memory ack delayed 3 cycles -> imem_req and imem_addr held stable 4 cycles; instr captured only on the ack cycle. Stray ack in EXEC -> ignored.
- stall=1 for 5 EXEC cycles -> instr_valid, pc and instr constant. retire_count (RETIRE_COUNT_EN) +1 only after release.
- pc=0xFFFFFFFF, sequential instruction -> next addr 0. rst_n dropped mid-FETCH -> imem_req=0 immediately, pc=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the multi-cycle MIPS core: owns PC and instruction register.
// Define RETIRE_COUNT_EN to build the retired-instruction counter.
module instruction_fetch_unit #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   imem_ack,
    input  logic [1:0]             PC_in_mux,
    input  logic                   branch,
    input  logic                   alu_zero,
    input  logic [PC_WIDTH-1:0]    reg_target,
    input  logic                   stall,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [5:0]             opcode,
    output logic                   instr_valid,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [PC_WIDTH-1:0]    pc_plus_one,
    output logic [31:0]            retire_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC
    } state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] next_pc;
    logic [PC_WIDTH-1:0] br_off;
    logic                retire;

    assign imem_addr   = pc;
    assign pc_plus_one = pc + 1'b1;
    assign opcode      = instr[INSTR_WIDTH-1 -: 6];
    assign br_off      = {{(PC_WIDTH-16){instr[15]}}, instr[15:0]};
    assign retire      = (state == EXEC) && !stall;

    // branch/alu_zero are only looked at on the sequential path
    always_comb begin
        next_pc = pc_plus_one;
        case (PC_in_mux)
            2'd0: begin
                if (branch && !alu_zero)
                    next_pc = pc_plus_one + br_off;
            end
            2'd1: next_pc = {pc_plus_one[PC_WIDTH-1:26], instr[25:0]};
            2'd2: next_pc = reg_target;
            default: next_pc = pc_plus_one;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        state       <= EXEC;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        pc          <= next_pc;
                        state       <= FETCH;
                        imem_req    <= 1'b1;
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef RETIRE_COUNT_EN
    logic [31:0] retire_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retire_q <= '0;
        else if (retire)
            retire_q <= retire_q + 32'd1;
    end

    assign retire_count = retire_q;
`else
    logic unused_retire;

    assign unused_retire = retire;
    assign retire_count  = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed programs, queued fetches.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [1:0]  PC_in_mux;
    logic        branch;
    logic        alu_zero;
    logic [31:0] reg_target;
    logic        stall;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus_one;
    logic [31:0] retire_count;

    instruction_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .PC_in_mux   (PC_in_mux),
        .branch      (branch),
        .alu_zero    (alu_zero),
        .reg_target  (reg_target),
        .stall       (stall),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus_one (pc_plus_one),
        .retire_count(retire_count)
    );

    typedef struct packed {
        logic [1:0]  mux;
        logic        br;
        logic        z;
        logic [31:0] tgt;
    } ctl_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] w;
    } ent_t;

    logic [31:0] mem [logic [31:0]];
    ctl_t        ctl [logic [31:0]];
    ent_t        q[$];
    ent_t        cur;
    logic        cur_ok;
    logic        pend;
    logic [31:0] last_instr;
    logic [31:0] exp_retire;
    int          ack_delay;
    int          stall_left;
    logic        stray;
    int          cnt;
    int          n_chk;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string n, input logic [31:0] act,
                         input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", n, act, expv);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // memory responder and control-unit stand-in, driven #1 after the edge
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hBAD0BAD0;
        PC_in_mux  = 2'd0;
        branch     = 1'b0;
        alu_zero   = 1'b0;
        reg_target = 32'h0;
        stall      = 1'b0;
        cnt        = 0;
        forever begin
            ctl_t c;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                imem_ack = 1'b0;
                cnt      = 0;
            end else if (imem_req) begin
                if (cnt == ack_delay) begin
                    imem_ack = 1'b1;
                    cnt      = 0;
                end else begin
                    imem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                imem_ack = stray;
                cnt      = 0;
            end
            imem_rdata = (imem_req && imem_ack) ? mem_rd(imem_addr)
                                                : 32'hDEADBEEF;
            c = ctl.exists(pc) ? ctl[pc] : '0;
            PC_in_mux  = c.mux;
            branch     = c.br;
            alu_zero   = c.z;
            reg_target = c.tgt;
            stall      = rst_n && instr_valid && (stall_left > 0);
            if (stall)
                stall_left--;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            exp_retire <= 32'h0;
        else if (instr_valid && !stall)
            exp_retire <= exp_retire + 32'd1;
    end

    // monitor: fetch addresses and executed words against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req) begin
                if (q.size() == 0) begin
                    if (imem_ack) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL extra_fetch: got addr %h expected none",
                                 imem_addr);
                    end
                end else begin
                    check("fetch_addr", imem_addr, q[0].a);
                    check("instr_hold", instr, last_instr);
                    if (imem_ack) begin
                        cur        = q.pop_front();
                        cur_ok     = 1'b1;
                        pend       = 1'b1;
                        last_instr = cur.w;
                    end
                end
            end
            if (instr_valid && cur_ok) begin
                check("instr", instr, cur.w);
                check("opcode", {26'h0, opcode}, {26'h0, cur.w[31:26]});
                check("pc", pc, cur.a);
                check("pc_plus_one", pc_plus_one, cur.a + 32'd1);
                pend = 1'b0;
            end
`ifdef RETIRE_COUNT_EN
            check("retire_count", retire_count, exp_retire);
`else
            check("retire_count", retire_count, 32'h0);
`endif
        end
    end

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_retire", retire_count, 32'h0);
        mem.delete();
        ctl.delete();
        q.delete();
        cur_ok     = 1'b0;
        pend       = 1'b0;
        last_instr = 32'h0;
        ack_delay  = 0;
        stall_left = 0;
        stray      = 1'b0;
    endtask

    task automatic release_dut();
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req", {31'h0, imem_req}, 32'h0);
    endtask

    task automatic exp(input logic [31:0] a, input logic [31:0] w);
        q.push_back({a, w});
        mem[a] = w;
    endtask

    task automatic setc(input logic [31:0] a, input logic [1:0] m,
                        input logic b, input logic z, input logic [31:0] t);
        ctl[a] = '{mux: m, br: b, z: z, tgt: t};
    endtask

    task automatic wait_done(input string n);
        int k;
        for (k = 0; k < 300; k++) begin
            @(posedge clk);
            #2;
            if (q.size() == 0 && !pend)
                break;
        end
        if (k == 300) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending expected 0", n, q.size());
        end
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        ack_delay  = 0;
        stall_left = 0;
        stray      = 1'b0;
        cur_ok     = 1'b0;
        pend       = 1'b0;
        last_instr = 32'h0;
        rst_n      = 1'b0;

        // sequential run from reset, zero-wait memory
        reset_dut();
        exp(32'h0, 32'h04000000);
        exp(32'h1, 32'h04000000);
        exp(32'h2, 32'h00000000);
        release_dut();
        wait_done("seq");

        // BNE taken back to 0x0D
        reset_dut();
        exp(32'h0, 32'h08000010);
        setc(32'h0, 2'd1, 1'b0, 1'b0, 32'h0);
        exp(32'h10, 32'h1400FFFC);
        setc(32'h10, 2'd0, 1'b1, 1'b0, 32'h0);
        exp(32'h0D, 32'h00000000);
        release_dut();
        wait_done("bne_taken");

        // BNE not taken
        reset_dut();
        exp(32'h0, 32'h08000010);
        setc(32'h0, 2'd1, 1'b0, 1'b0, 32'h0);
        exp(32'h10, 32'h1400FFFC);
        setc(32'h10, 2'd0, 1'b1, 1'b1, 32'h0);
        exp(32'h11, 32'h00000000);
        release_dut();
        wait_done("bne_not_taken");

        // J with branch=X, JR chain, PC wrap at all-ones
        reset_dut();
        exp(32'h0, 32'h08000010);
        setc(32'h0, 2'd1, 1'b0, 1'b0, 32'h0);
        exp(32'h10, 32'h1C000040);
        setc(32'h10, 2'd1, 1'bx, 1'b0, 32'h0);
        exp(32'h40, 32'h00000008);
        setc(32'h40, 2'd2, 1'b0, 1'b0, 32'h1234);
        exp(32'h1234, 32'h00000008);
        setc(32'h1234, 2'd2, 1'b0, 1'b0, 32'hFFFFFFFF);
        exp(32'hFFFFFFFF, 32'h04000000);
        q.push_back({32'h0, 32'h08000010});
        release_dut();
        wait_done("jumps");

        // slow memory, stray acks, 5-cycle stall, reserved mux ignores branch
        reset_dut();
        ack_delay  = 3;
        stall_left = 5;
        stray      = 1'b1;
        exp(32'h0, 32'h04000000);
        setc(32'h0, 2'd3, 1'b1, 1'b0, 32'h999);
        exp(32'h1, 32'h00000000);
        release_dut();
        wait_done("slow_stall");

        // reset dropped in the middle of a waiting fetch
        reset_dut();
        ack_delay = 3;
        exp(32'h0, 32'h04000000);
        release_dut();
        wait_done("pre_abort");
        repeat (2) @(posedge clk);
        #2;
        check("abort_pre_req", {31'h0, imem_req}, 32'h1);
        check("abort_pre_pc", pc, 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort_req", {31'h0, imem_req}, 32'h0);
        check("abort_pc", pc, 32'h0);
        check("abort_valid", {31'h0, instr_valid}, 32'h0);
        check("abort_instr", instr, 32'h0);
        check("abort_retire", retire_count, 32'h0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
